selftest_sequencer: RTL and testbench

Synthesizable self-test controller for the MIPS CPU component set (adder, data memory, instruction decode, muxes, PC, register file, shifter, sign extend). Launches each component self-test in turn over a start/done/pass handshake and bounds every test with a timeout. Collects a per-test result vector and reports a final all-passed flag. Sits above the component test wrappers and replaces fixed-delay waiting with a sequenced, cycle-accurate completion signal usable on the FPGA.

---
 rtl/selftest_pkg.sv | 6 +
 rtl/selftest_timer.sv | 19 +
 rtl/selftest_sequencer.sv | 102 ++++++++++
 tb/tb_selftest_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/selftest_pkg.sv
// selftest_pkg: shared state encoding and default sizing for the self-test sequencer
package selftest_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RECORD, FINISH} selftest_state_t;
    localparam int DEF_NUM_TESTS = 10;
    localparam int DEF_TIMEOUT_CYCLES = 2048;
endpackage

// File: rtl/selftest_timer.sv
// selftest_timer: saturating per-test timeout counter with clear/enable and expire flag
module selftest_timer #(
    parameter int CNT_W = 12,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [CNT_W-1:0] count;
    assign expired = count == CNT_W'(TIMEOUT_CYCLES - 1);
    // count WAIT cycles, holding at the expire value so it never wraps
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
endmodule

// File: rtl/selftest_sequencer.sv
// selftest_sequencer: launches component self-tests in order with timeouts; SELFTEST_MASK_EN adds test_mask to skip tests
module selftest_sequencer
    import selftest_pkg::*;
#(
    parameter int NUM_TESTS = DEF_NUM_TESTS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
`ifdef SELFTEST_MASK_EN
    input  logic [NUM_TESTS-1:0] test_mask,
`endif
    output logic [NUM_TESTS-1:0] test_start,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_pass,
    output logic busy,
    output logic done,
    output logic [NUM_TESTS-1:0] result,
    output logic [NUM_TESTS-1:0] timed_out,
    output logic [$clog2(NUM_TESTS)-1:0] current_test,
    output logic all_passed
);
    localparam int IW = $clog2(NUM_TESTS);
    selftest_state_t state, state_n;
    logic [NUM_TESTS-1:0] skip;
    logic [IW-1:0] first_idx, next_idx, idx_n;
    logic first_found, next_found, go, cur_done, cur_pass, expired;
`ifdef SELFTEST_MASK_EN
    assign skip = test_mask;
`else
    assign skip = '0;
`endif
    assign go = (state == IDLE || state == FINISH) && start;
    assign cur_done = test_done[current_test];
    assign cur_pass = test_pass[current_test];
    assign idx_n = state == RECORD ? next_idx : first_idx;
    assign all_passed = done & (&result);
    selftest_timer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(go || state == LAUNCH),
        .enable(state == WAIT),
        .expired(expired)
    );
    // lowest unskipped test overall and lowest unskipped test after the current one
    always_comb begin
        first_found = 1'b0;
        first_idx = '0;
        next_found = 1'b0;
        next_idx = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (!skip[i]) begin
                first_found = 1'b1;
                first_idx = IW'(i);
            end
            if (!skip[i] && IW'(i) > current_test) begin
                next_found = 1'b1;
                next_idx = IW'(i);
            end
        end
    end
    // next-state decode; a run with every test skipped passes through RECORD straight to FINISH
    always_comb begin
        state_n = state;
        case (state)
            IDLE, FINISH: if (start) state_n = first_found ? LAUNCH : RECORD;
            LAUNCH: state_n = WAIT;
            WAIT: if (cur_done || expired) state_n = RECORD;
            RECORD: state_n = next_found ? LAUNCH : FINISH;
            default: state_n = IDLE;
        endcase
    end
    // state, registered status outputs and per-test result vectors; done beats timeout in WAIT
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            test_start <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            timed_out <= '0;
            current_test <= '0;
        end else begin
            state <= state_n;
            busy <= state_n inside {LAUNCH, WAIT, RECORD};
            done <= state_n == FINISH;
            test_start <= state_n == LAUNCH ? NUM_TESTS'(1) << idx_n : '0;
            if (go) begin
                result <= skip;
                timed_out <= '0;
                current_test <= first_idx;
            end
            if (state == WAIT && cur_done) result[current_test] <= cur_pass;
            else if (state == WAIT && expired) begin
                result[current_test] <= 1'b0;
                timed_out[current_test] <= 1'b1;
            end
            if (state == RECORD && next_found) current_test <= next_idx;
        end
endmodule

// File: tb/tb_selftest_sequencer.sv
// tb_selftest_sequencer: directed bench with scripted per-test responders and hand-computed expectations
module tb_selftest_sequencer;
    localparam int N = 10;
    localparam int TO = 16;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [N-1:0] test_done, test_pass, test_start, result, timed_out;
    logic busy, done, all_passed;
    logic [3:0] current_test;
`ifdef SELFTEST_MASK_EN
    logic [N-1:0] test_mask = '0;
`endif
    int n_tests = 0, n_fail = 0, cyc_cnt = 0, c = 0;
    int dly [N];
    logic pas [N];
    logic [N-1:0] spur = '0;
    int launch_idx [$];
    int launch_cyc [N];
    int act = -1, cnt = 0;

    selftest_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(TO), .CNT_W(12)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef SELFTEST_MASK_EN
        .test_mask(test_mask),
`endif
        .test_start(test_start),
        .test_done(test_done),
        .test_pass(test_pass),
        .busy(busy),
        .done(done),
        .result(result),
        .timed_out(timed_out),
        .current_test(current_test),
        .all_passed(all_passed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_all(input int d);
        for (int i = 0; i < N; i++) begin
            dly[i] = d;
            pas[i] = 1'b1;
        end
    endtask

    task automatic launch();
        launch_idx.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("done_rise", done, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ts"}, test_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_res"}, result, 0);
        check({tag, "_to"}, timed_out, 0);
        check({tag, "_cur"}, current_test, 0);
        check({tag, "_allp"}, all_passed, 0);
    endtask

    task automatic check_order();
        check("n_launch", launch_idx.size(), N);
        foreach (launch_idx[i]) check($sformatf("order%0d", i), launch_idx[i], i);
    endtask

    // responder: after a launch pulse, answer with done/pass on the scripted cycle (0 = never)
    initial begin
        test_done = '0;
        test_pass = '0;
        forever begin
            @(negedge clk);
            test_done = spur;
            test_pass = '0;
            if (reset) act = -1;
            else if (test_start != '0) begin
                for (int i = 0; i < N; i++)
                    if (test_start[i]) begin
                        launch_idx.push_back(i);
                        launch_cyc[i] = cyc_cnt;
                        act = i;
                    end
                cnt = 0;
            end else if (act >= 0) begin
                cnt++;
                if (dly[act] != 0 && cnt == dly[act]) begin
                    test_done[act] = 1'b1;
                    test_pass[act] = pas[act];
                    act = -1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_all(3);
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_quiet", launch_idx.size(), 0);
        // all tests pass, 5 cycles each
        launch();
        check("first_pulse", test_start, 10'h001);
        check("busy_on", busy, 1);
        wait_done(c);
        check("all_lat", c, 50);
        check("all_res", result, 10'h3FF);
        check("all_to", timed_out, 0);
        check("all_allp", all_passed, 1);
        check("all_busy", busy, 0);
        check("pitch", launch_cyc[1] - launch_cyc[0], 5);
        check_order();
        // test 4 fails, test 7 times out
        set_all(3);
        pas[4] = 1'b0;
        dly[7] = 0;
        launch();
        check("clr_res", result, 0);
        wait_done(c);
        check("ft_lat", c, 63);
        check("ft_res", result, 10'b1101101111);
        check("ft_to", timed_out, 10'b0010000000);
        check("ft_allp", all_passed, 0);
        check("t7_occ", launch_cyc[8] - launch_cyc[7], 18);
        // done lands on the last WAIT cycle: done wins
        set_all(3);
        dly[2] = 16;
        launch();
        check("clr_to", timed_out, 0);
        wait_done(c);
        check("edge_res", result, 10'h3FF);
        check("edge_to", timed_out, 0);
        check("t2_occ", launch_cyc[3] - launch_cyc[2], 18);
        // spurious done on test 9 during test 0, start pulsed while busy
        set_all(3);
        launch();
        spur = 10'h200;
        repeat (3) @(negedge clk);
        spur = '0;
        repeat (15) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        check("disc_res", result, 10'h3FF);
        check_order();
        // reset while waiting on test 5
        set_all(3);
        dly[5] = 0;
        launch();
        for (int i = 0; i < 200 && launch_idx.size() < 6; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("at_t5", current_test, 5);
        check("t5_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_zero("mid");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("no_relaunch", launch_idx.size(), 6);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        dly[5] = 3;
        launch();
        check("relaunch0", test_start, 10'h001);
        wait_done(c);
        check("re_lat", c, 50);
        check("re_res", result, 10'h3FF);
`ifdef SELFTEST_MASK_EN
        begin
            logic [N-1:0] seen;
            test_mask = 10'h0F0;
            set_all(3);
            launch();
            wait_done(c);
            seen = '0;
            foreach (launch_idx[i]) seen[launch_idx[i]] = 1'b1;
            check("mask_lat", c, 30);
            check("mask_res", result, 10'h3FF);
            check("mask_seen", seen, 10'h30F);
            check("mask_cnt", launch_idx.size(), 6);
            test_mask = '0;
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
